// File: rtl/hazard_scoreboard.sv
// Hazard controller for the 5-stage MIPS pipeline: tracks the write-back destinations
// in EX/MEM/WB to raise load-use and branch-in-ID stalls and to drive the EX forwarding selects.
module hazard_scoreboard #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_is_branch,
  input  logic             flush,
  output logic             stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] dst;
    logic             ld;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
  } entry_t;

  localparam entry_t BUBBLE = '0;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  entry_t           ex_q, ex_d;
  entry_t           mem_q, mem_d;
  entry_t           wb_q, wb_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic hz_ex_rs, hz_ex_rt;
  logic hz_mem_rs, hz_mem_rt;
  logic load_use, branch_ex, branch_mem_ld;
  logic stall_c;

  // $0 is hard-wired, so a write to it never creates a dependence.
  function automatic logic match(input entry_t e, input logic [REG_W-1:0] r);
    return e.v && (e.dst == r) && (r != '0);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Younger producer (MEM) wins over the older one (WB).
  function automatic logic [1:0] fwd_sel(input entry_t m, input entry_t w,
                                         input logic [REG_W-1:0] r);
    if (match(m, r))
      return FWD_MEM;
    else if (match(w, r))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  always_comb begin
    hz_ex_rs      = id_use_rs && match(ex_q, id_rs);
    hz_ex_rt      = id_use_rt && match(ex_q, id_rt);
    hz_mem_rs     = id_use_rs && match(mem_q, id_rs);
    hz_mem_rt     = id_use_rt && match(mem_q, id_rt);
    load_use      = ex_q.ld && (hz_ex_rs || hz_ex_rt);
    branch_ex     = id_is_branch && (hz_ex_rs || hz_ex_rt);
    branch_mem_ld = id_is_branch && mem_q.ld && (hz_mem_rs || hz_mem_rt);
    stall_c       = id_valid && !flush && (load_use || branch_ex || branch_mem_ld);
  end

  // ID -> EX boundary: a stalled, flushed or empty ID slot enters EX as a bubble.
  always_comb begin
    ex_d = BUBBLE;
    if (id_valid && !stall_c && !flush) begin
      ex_d.v   = id_reg_write;
      ex_d.dst = id_dst;
      ex_d.ld  = id_mem_read && id_reg_write;
      ex_d.rs  = id_rs;
      ex_d.rt  = id_rt;
    end
    mem_d         = ex_q;
    wb_d          = mem_q;
    stall_count_d = stall_c ? sat_inc(stall_count_q) : stall_count_q;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ex_q          <= BUBBLE;
      mem_q         <= BUBBLE;
      wb_q          <= BUBBLE;
      stall_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      stall_count_q <= stall_count_d;
    end
  end

  always_comb begin
    stall       = stall_c;
    pc_write    = !stall_c;
    ifid_write  = !stall_c;
    fwd_a       = fwd_sel(mem_q, wb_q, ex_q.rs);
    fwd_b       = fwd_sel(mem_q, wb_q, ex_q.rt);
    stall_count = stall_count_q;
  end

  // Source fields and the load flag travel with the entry but are only consumed in EX/MEM.
  logic unused_fields;
  assign unused_fields = ^{mem_q.rs, mem_q.rt, wb_q.ld, wb_q.rs, wb_q.rt};

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stimulus pushes expected outputs into a queue,
// a monitor pops and compares them on the falling clock edge (or on an explicit sample strobe).
module tb_hazard_scoreboard;
  localparam int REG_W = 5;
  localparam int CNT_W = 8;

  logic             Clk = 1'b0;
  logic             Rst = 1'b1;
  logic             id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read, id_is_branch, flush;
  logic [REG_W-1:0] id_rs, id_rt, id_dst;
  logic             stall, pc_write, ifid_write;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_count;
  logic             smp = 1'b0;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst(Rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_is_branch(id_is_branch),
    .flush(flush), .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dst;
    logic       rw;
    logic       mr;
    logic       br;
  } instr_t;

  typedef struct packed {
    logic             stall;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic [CNT_W-1:0] cnt;
    logic             chk_fwd;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  cur;
  string cur_nm;

  function automatic instr_t i_nop();
    return '0;
  endfunction
  function automatic instr_t i_alu(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    instr_t x = '0;
    x.v = 1'b1; x.rs = s; x.rt = t; x.urs = 1'b1; x.urt = 1'b1; x.dst = d; x.rw = 1'b1;
    return x;
  endfunction
  function automatic instr_t i_lw(input logic [4:0] d, input logic [4:0] base);
    instr_t x = '0;
    x.v = 1'b1; x.rs = base; x.rt = d; x.urs = 1'b1; x.dst = d; x.rw = 1'b1; x.mr = 1'b1;
    return x;
  endfunction
  function automatic instr_t i_beq(input logic [4:0] s, input logic [4:0] t);
    instr_t x = '0;
    x.v = 1'b1; x.rs = s; x.rt = t; x.urs = 1'b1; x.urt = 1'b1; x.br = 1'b1;
    return x;
  endfunction
  function automatic instr_t i_jal();
    instr_t x = '0;
    x.v = 1'b1; x.dst = 5'd31; x.rw = 1'b1;
    return x;
  endfunction

  task automatic apply(input instr_t x, input logic fl);
    id_valid = x.v; id_rs = x.rs; id_rt = x.rt; id_use_rs = x.urs; id_use_rt = x.urt;
    id_dst = x.dst; id_reg_write = x.rw; id_mem_read = x.mr; id_is_branch = x.br;
    flush = fl;
  endtask

  task automatic push_exp(input logic st, input logic [1:0] fa, input logic [1:0] fb,
                          input logic [CNT_W-1:0] cnt, input logic cf, input string nm);
    exp_t e;
    e.stall = st; e.fa = fa; e.fb = fb; e.cnt = cnt; e.chk_fwd = cf;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic step(input instr_t x, input logic fl, input logic st, input logic [1:0] fa,
                      input logic [1:0] fb, input logic [CNT_W-1:0] cnt, input logic cf,
                      input string nm);
    @(posedge Clk);
    #1;
    apply(x, fl);
    push_exp(st, fa, fb, cnt, cf, nm);
  endtask

  task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s %s: actual=%0h required=%0h", nm, fld, act, req);
    end
  endtask

  always @(negedge Clk or posedge smp) begin
    if (exp_q.size() > 0) begin
      cur    = exp_q.pop_front();
      cur_nm = name_q.pop_front();
      cmp(cur_nm, "stall", 32'(stall), 32'(cur.stall));
      cmp(cur_nm, "pc_write", 32'(pc_write), 32'(!cur.stall));
      cmp(cur_nm, "ifid_write", 32'(ifid_write), 32'(!cur.stall));
      cmp(cur_nm, "stall_count", 32'(stall_count), 32'(cur.cnt));
      if (cur.chk_fwd) begin
        cmp(cur_nm, "fwd_a", 32'(fwd_a), 32'(cur.fa));
        cmp(cur_nm, "fwd_b", 32'(fwd_b), 32'(cur.fb));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    instr_t sp;
    sp = '0;
    sp.v = 1'b1; sp.rs = 5'd8; sp.urs = 1'b1; sp.dst = 5'd8; sp.rw = 1'b1; sp.mr = 1'b1; sp.br = 1'b1;

    apply(i_nop(), 1'b0);
    @(posedge Clk);
    @(posedge Clk);
    #1;
    push_exp(1'b0, 2'b00, 2'b00, 8'd0, 1'b1, "reset_state");
    @(negedge Clk);
    #2 Rst = 1'b0;

    // lw $8 ; add $9,$8,$10
    step(i_lw(5'd8, 5'd0),        1'b0, 1'b0, 2'b00, 2'b00, 8'd0, 1'b1, "lw_issue");
    step(i_alu(5'd9, 5'd8, 5'd10), 1'b0, 1'b1, 2'b00, 2'b00, 8'd0, 1'b1, "lw_use_stall");
    step(i_alu(5'd9, 5'd8, 5'd10), 1'b0, 1'b0, 2'b00, 2'b00, 8'd1, 1'b1, "lw_use_release");
    step(i_nop(),                 1'b0, 1'b0, 2'b01, 2'b00, 8'd1, 1'b1, "lw_use_wb_fwd");

    // add $8 ; beq $8,$9   then   lw $8 ; beq $8,$9
    step(i_alu(5'd8, 5'd1, 5'd2),  1'b0, 1'b0, 2'b00, 2'b00, 8'd1, 1'b1, "alu_br_issue");
    step(i_beq(5'd8, 5'd9),        1'b0, 1'b1, 2'b00, 2'b00, 8'd1, 1'b1, "alu_br_stall");
    step(i_beq(5'd8, 5'd9),        1'b0, 1'b0, 2'b00, 2'b00, 8'd2, 1'b1, "alu_br_release");
    step(i_lw(5'd8, 5'd0),        1'b0, 1'b0, 2'b01, 2'b00, 8'd2, 1'b1, "ld_br_issue");
    step(i_beq(5'd8, 5'd9),        1'b0, 1'b1, 2'b00, 2'b00, 8'd2, 1'b1, "ld_br_stall1");
    step(i_beq(5'd8, 5'd9),        1'b0, 1'b1, 2'b00, 2'b00, 8'd3, 1'b1, "ld_br_stall2");
    step(i_beq(5'd8, 5'd9),        1'b0, 1'b0, 2'b00, 2'b00, 8'd4, 1'b1, "ld_br_release");
    step(i_nop(),                 1'b0, 1'b0, 2'b00, 2'b00, 8'd4, 1'b1, "ld_br_drain");

    // add $8 ; add $8 ; sub $9,$8,$8
    step(i_alu(5'd8, 5'd1, 5'd2),  1'b0, 1'b0, 2'b00, 2'b00, 8'd4, 1'b1, "prio_add_a");
    step(i_alu(5'd8, 5'd3, 5'd4),  1'b0, 1'b0, 2'b00, 2'b00, 8'd4, 1'b1, "prio_add_b");
    step(i_alu(5'd9, 5'd8, 5'd8),  1'b0, 1'b0, 2'b00, 2'b00, 8'd4, 1'b1, "prio_sub");
    step(i_nop(),                 1'b0, 1'b0, 2'b10, 2'b10, 8'd4, 1'b1, "prio_mem_over_wb");

    // lw $0 ; add $9,$0,$0 ; jal ; add $10,$31,$5
    step(i_nop(),                 1'b0, 1'b0, 2'b00, 2'b00, 8'd4, 1'b1, "r0_gap");
    step(i_lw(5'd0, 5'd0),        1'b0, 1'b0, 2'b00, 2'b00, 8'd4, 1'b1, "r0_lw");
    step(i_alu(5'd9, 5'd0, 5'd0),  1'b0, 1'b0, 2'b00, 2'b00, 8'd4, 1'b1, "r0_no_stall");
    step(i_jal(),                 1'b0, 1'b0, 2'b00, 2'b00, 8'd4, 1'b1, "r0_no_mem_fwd");
    step(i_alu(5'd10, 5'd31, 5'd5), 1'b0, 1'b0, 2'b00, 2'b00, 8'd4, 1'b1, "r0_no_wb_fwd");
    step(i_nop(),                 1'b0, 1'b0, 2'b10, 2'b00, 8'd4, 1'b1, "r31_fwd");

    // flush over a load-use hazard
    step(i_lw(5'd8, 5'd0),        1'b0, 1'b0, 2'b00, 2'b00, 8'd4, 1'b1, "flush_lw");
    step(i_alu(5'd9, 5'd8, 5'd10), 1'b1, 1'b0, 2'b00, 2'b00, 8'd4, 1'b1, "flush_beats_stall");
    step(i_alu(5'd9, 5'd8, 5'd10), 1'b0, 1'b0, 2'b00, 2'b00, 8'd4, 1'b1, "flush_bubble");
    step(i_nop(),                 1'b0, 1'b0, 2'b01, 2'b00, 8'd4, 1'b1, "flush_refetch_fwd");

    // asynchronous reset in the middle of a stall
    step(i_lw(5'd8, 5'd0),        1'b0, 1'b0, 2'b00, 2'b00, 8'd4, 1'b1, "rst_lw");
    step(i_alu(5'd9, 5'd8, 5'd10), 1'b0, 1'b1, 2'b00, 2'b00, 8'd4, 1'b1, "rst_pre_stall");
    @(negedge Clk);
    #2 Rst = 1'b1;
    push_exp(1'b0, 2'b00, 2'b00, 8'd0, 1'b1, "rst_async");
    #1 smp = 1'b1;
    #1 smp = 1'b0;
    @(negedge Clk);
    #2 Rst = 1'b0;
    step(i_nop(),                 1'b0, 1'b0, 2'b00, 2'b00, 8'd0, 1'b1, "rst_after");

    // repeated branch-on-load hazards: two stalls every three cycles
    for (int i = 0; i < 30; i++) begin
      @(posedge Clk);
      #1 apply(sp, 1'b0);
    end
    step(i_nop(), 1'b0, 1'b0, 2'b00, 2'b00, 8'd20, 1'b0, "cnt_20");
    for (int i = 0; i < 400; i++) begin
      @(posedge Clk);
      #1 apply(sp, 1'b0);
    end
    step(i_nop(), 1'b0, 1'b0, 2'b00, 2'b00, 8'hff, 1'b0, "cnt_saturated");
    step(i_nop(), 1'b0, 1'b0, 2'b00, 2'b00, 8'hff, 1'b0, "cnt_held");

    @(posedge Clk);
    @(negedge Clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
